// File: rtl/fb_mem_arb_pkg.sv
// ============================================================================
// Module   : fb_mem_arb_pkg
// Purpose  : Shared types and constants for the frame-buffer BRAM arbiter.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

package fb_mem_arb_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RD   = 2'd1,
    WR   = 2'd2
  } state_t;

  localparam int BURST_CNT_W    = 8;
  localparam int DEF_BRAM_DEPTH = 307200;
  localparam int DEF_BRAM_WIDTH = 12;

endpackage

`default_nettype wire

// File: rtl/fb_mem_arb_vpipe.sv
// ============================================================================
// Module   : fb_mem_arb_vpipe
// Purpose  : DEPTH-stage read-valid shift register, async active-low clear.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module fb_mem_arb_vpipe #(
  parameter int DEPTH = 1
) (
  input  logic i_clk,
  input  logic i_rstn,
  input  logic i_vld,
  output logic o_vld
);

  logic [DEPTH-1:0] r_sr;

  generate
    if (DEPTH == 1) begin : g_single
      always_ff @(posedge i_clk or negedge i_rstn) begin
        if (!i_rstn) r_sr <= '0;
        else         r_sr <= i_vld;
      end
    end else begin : g_multi
      always_ff @(posedge i_clk or negedge i_rstn) begin
        if (!i_rstn) r_sr <= '0;
        else         r_sr <= {r_sr[DEPTH-2:0], i_vld};
      end
    end
  endgenerate

  assign o_vld = r_sr[DEPTH-1];

endmodule

`default_nettype wire

// File: rtl/fb_mem_arb.sv
// ============================================================================
// Module   : fb_mem_arb
// Purpose  : Single-port BRAM arbiter, reader-priority with bounded bursts.
//            FB_MEM_ARB_RR_EN: IDLE ties go to the side not served last.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module fb_mem_arb
  import fb_mem_arb_pkg::*;
#(
  parameter int BRAM_WIDTH  = DEF_BRAM_WIDTH,
  parameter int BRAM_DEPTH  = DEF_BRAM_DEPTH,
  parameter int BRAM_RD_LAT = 1,
  parameter int BURST_MAX   = 16,
  localparam int AW         = $clog2(BRAM_DEPTH)
) (
  input  logic                  i_clk,
  input  logic                  i_rstn,
  input  logic                  i_wr_req,
  input  logic [AW-1:0]         i_wr_addr,
  input  logic [BRAM_WIDTH-1:0] i_wr_data,
  output logic                  o_wr_gnt,
  input  logic                  i_rd_req,
  input  logic [AW-1:0]         i_rd_addr,
  output logic                  o_rd_gnt,
  output logic                  o_rd_valid,
  output logic [BRAM_WIDTH-1:0] o_rd_data,
  output logic                  o_en,
  output logic                  o_we,
  output logic [AW-1:0]         o_addr,
  output logic [BRAM_WIDTH-1:0] o_wdata,
  input  logic [BRAM_WIDTH-1:0] i_rdata
);

  localparam logic [BURST_CNT_W-1:0] C_BURST_MAX = BURST_CNT_W'(BURST_MAX);

  state_t                 r_state, w_state_nxt;
  logic [BURST_CNT_W-1:0] r_cnt, w_cnt_nxt;
  logic                   w_rd_gnt, w_wr_gnt;
  logic                   w_tie_to_rd;

`ifdef FB_MEM_ARB_RR_EN
  logic r_last_wr;

  always_ff @(posedge i_clk or negedge i_rstn) begin
    if (!i_rstn)                  r_last_wr <= 1'b1;
    else if (w_rd_gnt | w_wr_gnt) r_last_wr <= w_wr_gnt;
  end

  assign w_tie_to_rd = r_last_wr;
`else
  assign w_tie_to_rd = 1'b1;
`endif

  // Owner keeps the port past BURST_MAX only while the other side is quiet.
  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    w_rd_gnt    = 1'b0;
    w_wr_gnt    = 1'b0;
    if (i_rstn) begin
      case (r_state)
        IDLE: begin
          if (i_rd_req && (!i_wr_req || w_tie_to_rd)) begin
            w_rd_gnt    = 1'b1;
            w_state_nxt = RD;
            w_cnt_nxt   = BURST_CNT_W'(1);
          end else if (i_wr_req) begin
            w_wr_gnt    = 1'b1;
            w_state_nxt = WR;
            w_cnt_nxt   = BURST_CNT_W'(1);
          end else begin
            w_cnt_nxt   = '0;
          end
        end
        RD: begin
          if (i_rd_req && ((r_cnt < C_BURST_MAX) || !i_wr_req)) begin
            w_rd_gnt = 1'b1;
            if (r_cnt < C_BURST_MAX) w_cnt_nxt = r_cnt + 1'b1;
          end else if (i_wr_req) begin
            w_wr_gnt    = 1'b1;
            w_state_nxt = WR;
            w_cnt_nxt   = BURST_CNT_W'(1);
          end else begin
            w_state_nxt = IDLE;
            w_cnt_nxt   = '0;
          end
        end
        WR: begin
          if (i_wr_req && ((r_cnt < C_BURST_MAX) || !i_rd_req)) begin
            w_wr_gnt = 1'b1;
            if (r_cnt < C_BURST_MAX) w_cnt_nxt = r_cnt + 1'b1;
          end else if (i_rd_req) begin
            w_rd_gnt    = 1'b1;
            w_state_nxt = RD;
            w_cnt_nxt   = BURST_CNT_W'(1);
          end else begin
            w_state_nxt = IDLE;
            w_cnt_nxt   = '0;
          end
        end
        default: begin
          w_state_nxt = IDLE;
          w_cnt_nxt   = '0;
        end
      endcase
    end
  end

  always_ff @(posedge i_clk or negedge i_rstn) begin
    if (!i_rstn) begin
      r_state <= IDLE;
      r_cnt   <= '0;
      o_en    <= 1'b0;
      o_we    <= 1'b0;
      o_addr  <= '0;
      o_wdata <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
      o_en    <= w_rd_gnt | w_wr_gnt;
      o_we    <= w_wr_gnt;
      if (w_wr_gnt) begin
        o_addr  <= i_wr_addr;
        o_wdata <= i_wr_data;
      end else if (w_rd_gnt) begin
        o_addr  <= i_rd_addr;
      end
    end
  end

  assign o_rd_gnt  = w_rd_gnt;
  assign o_wr_gnt  = w_wr_gnt;
  assign o_rd_data = i_rdata;

  // The token starts from the registered read strobe, adding the issue cycle.
  fb_mem_arb_vpipe #(
    .DEPTH (BRAM_RD_LAT)
  ) u_vpipe (
    .i_clk  (i_clk),
    .i_rstn (i_rstn),
    .i_vld  (o_en & ~o_we),
    .o_vld  (o_rd_valid)
  );

endmodule

`default_nettype wire

// File: tb/tb_fb_mem_arb.sv
// ============================================================================
// Module   : tb_fb_mem_arb
// Purpose  : Self-checking bench for fb_mem_arb against a policy-level model.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_fb_mem_arb;

  localparam int W    = 12;
  localparam int AW   = 19;
  localparam int BMAX = 4;
  localparam int LAT  = 1;

  logic          clk = 1'b0;
  logic          rstn;
  logic          wr_req, rd_req;
  logic [AW-1:0] wr_addr, rd_addr;
  logic [W-1:0]  wr_data, rdata;
  logic          wr_gnt, rd_gnt, rd_valid, en, we;
  logic [W-1:0]  rd_data, wdata;
  logic [AW-1:0] addr;

  always #5 clk = ~clk;

  fb_mem_arb #(
    .BRAM_WIDTH  (W),
    .BRAM_DEPTH  (307200),
    .BRAM_RD_LAT (LAT),
    .BURST_MAX   (BMAX)
  ) dut (
    .i_clk      (clk),
    .i_rstn     (rstn),
    .i_wr_req   (wr_req),
    .i_wr_addr  (wr_addr),
    .i_wr_data  (wr_data),
    .o_wr_gnt   (wr_gnt),
    .i_rd_req   (rd_req),
    .i_rd_addr  (rd_addr),
    .o_rd_gnt   (rd_gnt),
    .o_rd_valid (rd_valid),
    .o_rd_data  (rd_data),
    .o_en       (en),
    .o_we       (we),
    .o_addr     (addr),
    .o_wdata    (wdata),
    .i_rdata    (rdata)
  );

  int n_tests = 0;
  int n_fail  = 0;

  // Model: who holds the port (0 none, 1 reader, 2 writer) and its run length.
  int            owner, run, cyc;
  bit            last_wr;
  logic          exp_en, exp_we;
  logic [AW-1:0] exp_addr;
  logic [W-1:0]  exp_wdata;
  int            due[$];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    owner = 0; run = 0; last_wr = 1'b1;
    exp_en = 1'b0; exp_we = 1'b0; exp_addr = '0; exp_wdata = '0;
    due.delete();
  endtask

  function automatic int decide(bit rq_rd, bit rq_wr);
    bit own_req, oth_req;
    if (owner == 0) begin
      if (rq_rd && rq_wr) begin
`ifdef FB_MEM_ARB_RR_EN
        return last_wr ? 1 : 2;
`else
        return 1;
`endif
      end
      return rq_rd ? 1 : (rq_wr ? 2 : 0);
    end
    own_req = (owner == 1) ? rq_rd : rq_wr;
    oth_req = (owner == 1) ? rq_wr : rq_rd;
    if (own_req && (run < BMAX || !oth_req)) return owner;
    if (oth_req) return 3 - owner;
    return 0;
  endfunction

  task automatic hold_reset(input int n);
    rstn = 1'b0; rd_req = 1'b1; wr_req = 1'b1;
    #1;
    model_reset();
    chk("rst_en_async", en, 0);
    chk("rst_we", we, 0);
    chk("rst_addr", addr, 0);
    chk("rst_wdata", wdata, 0);
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      chk("rst_rd_gnt", rd_gnt, 0);
      chk("rst_wr_gnt", wr_gnt, 0);
      chk("rst_en", en, 0);
      chk("rst_rd_valid", rd_valid, 0);
    end
    @(posedge clk); cyc++; #1;
    rstn = 1'b1;
  endtask

  // One clock cycle; returns the observed grant (bit0 reader, bit1 writer).
  task automatic step(input bit rq_rd, input bit rq_wr, input logic [AW-1:0] ra,
                      input logic [AW-1:0] wa, input logic [W-1:0] wd, output int obs_g);
    int  g;
    bit  exp_v;
    rd_req = rq_rd; wr_req = rq_wr; rd_addr = ra; wr_addr = wa; wr_data = wd;
    rdata  = W'($urandom);
    @(negedge clk);
    g     = decide(rq_rd, rq_wr);
    obs_g = {30'd0, wr_gnt, rd_gnt};
    chk("rd_gnt", rd_gnt, (g == 1) ? 1 : 0);
    chk("wr_gnt", wr_gnt, (g == 2) ? 1 : 0);
    if (g == 0) begin
      owner = 0; run = 0;
    end else if (g == owner) begin
      if (run < BMAX) run++;
    end else begin
      owner = g; run = 1;
    end
    if (g != 0) last_wr = (g == 2);
    exp_en = (g != 0);
    exp_we = (g == 2);
    if (g == 2) begin exp_addr = wa; exp_wdata = wd; end
    if (g == 1) begin exp_addr = ra; due.push_back(cyc + 1 + LAT); end
    @(posedge clk); cyc++; #1;
    chk("en", en, exp_en);
    chk("we", we, exp_we);
    chk("addr", addr, exp_addr);
    chk("wdata", wdata, exp_wdata);
    exp_v = (due.size() > 0) && (due[0] == cyc);
    if (exp_v) void'(due.pop_front());
    chk("rd_valid", rd_valid, exp_v);
    if (exp_v) chk("rd_data", rd_data, rdata);
  endtask

  initial begin
    int g;
    int pat[10];
    int exp_pat[10];
    cyc = 0;
    rd_req = 0; wr_req = 0; rd_addr = '0; wr_addr = '0; wr_data = '0; rdata = '0;
    exp_pat = '{1, 1, 1, 1, 2, 2, 2, 2, 1, 1};

    // Reset with both requesting, then reader must win the first cycle.
    hold_reset(3);
    step(1, 1, 19'h00010, 19'h00020, 12'h111, g);
    chk("first_gnt_reader", g, 1);
    chk("first_en", en, 1);
    chk("first_we", we, 0);
    step(0, 0, '0, '0, '0, g);
    step(0, 0, '0, '0, '0, g);

    // Single read.
    step(1, 0, 19'h00123, '0, '0, g);
    chk("single_addr", addr, 19'h00123);
    step(0, 0, '0, '0, '0, g);
    chk("single_valid", rd_valid, 1);
    step(0, 0, '0, '0, '0, g);

    // Write stream.
    for (int i = 0; i < 5; i++) begin
      step(0, 1, '0, AW'(i), W'(12'hA00 + i), g);
      chk("wstream_gnt", g, 2);
      chk("wstream_wdata", wdata, 12'hA00 + i);
    end
    step(0, 0, '0, '0, '0, g);

    // Contention with continuous requests on both sides.
    for (int i = 0; i < 10; i++) begin
      step(1, 1, AW'(19'h100 + i), AW'(19'h200 + i), W'(i), g);
      pat[i] = g;
    end
    for (int i = 0; i < 10; i++) chk("contention_pattern", pat[i], exp_pat[i]);
    step(0, 0, '0, '0, '0, g);
    step(0, 0, '0, '0, '0, g);

    // Reset the cycle after a read grant: the read must never complete.
    step(1, 0, 19'h00777, '0, '0, g);
    hold_reset(3);
    step(0, 0, '0, '0, '0, g);
    chk("midrst_no_valid", rd_valid, 0);

    // IDLE tie after writer served, then after reader served.
    step(0, 1, '0, 19'h00050, 12'h050, g);
    step(0, 0, '0, '0, '0, g);
    step(1, 1, 19'h00060, 19'h00061, 12'h061, g);
    chk("tie_after_wr", g, 1);
    step(0, 0, '0, '0, '0, g);
    step(1, 1, 19'h00070, 19'h00071, 12'h071, g);
`ifdef FB_MEM_ARB_RR_EN
    chk("tie_after_rd", g, 2);
`else
    chk("tie_after_rd", g, 1);
`endif
    step(0, 0, '0, '0, '0, g);
    step(0, 0, '0, '0, '0, g);

    // Randomized traffic, including addresses beyond the depth.
    for (int i = 0; i < 400; i++) begin
      step(($urandom_range(0, 9) < 6), ($urandom_range(0, 9) < 6),
           AW'($urandom), AW'($urandom), W'($urandom), g);
      chk("one_hot_gnt", (g == 3) ? 1 : 0, 0);
    end
    step(0, 0, '0, '0, '0, g);
    step(0, 0, '0, '0, '0, g);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

`default_nettype wire
